grid_cursor_ctrl: RTL and testbench
===================================

# grid_cursor_ctrl

Parametrised board controller for the game datapath. It holds a ROWS×COLS array of cells and a cursor that moves in two dimensions with wrap-around. Selections are committed as alternating player marks, with occupancy checking, a move counter and board-full detection. It is the generalised successor of the fixed 16-cell linear-cursor mover and sits between the debounced button inputs and the display/VGA cell renderer.

## Interface
Parameters:
- ROWS, 4, board rows (≥2)
- COLS, 4, board columns (≥2)
- CELL_W, 4, bits per cell code (≥2)

Derived: N = ROWS*COLS; IDX_W = $clog2(N); CNT_W = $clog2(N+1).

Ports (all inputs synchronous to clk; button synchronisers and debouncers sit upstream):
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- move  in  1  level; rising edge steps cursor +1 (linear, wraps N-1→0)
- move_back  in  1  level; rising edge steps cursor −1 (wraps 0→N-1)
- move_down  in  1  level; rising edge steps cursor one row down, same column (row ROWS-1→0)
- select  in  1  level; rising edge commits current player's mark at cursor
- clear  in  1  level; rising edge empties the board and restarts the game
- cells  out  N*CELL_W  flat board; cell i occupies bits [i*CELL_W +: CELL_W]
- cursor  out  IDX_W  current cell index
- player  out  1  0 = player 1 to move, 1 = player 2 to move
- counter  out  CNT_W  number of committed marks
- full  out  1  high when counter == N
- reject  out  1  one-cycle pulse on a refused select

## Operation
- Each of the five inputs passes through its own rising-edge detector: previous-sample register, reset to 0. A held level produces exactly one event.
- States: PLAY and FULL.
- Priority when several events occur in the same cycle: clear > select > move > move_back > move_down. Only the highest-priority event acts; the others are discarded, not queued.
- clear, from either state: all cells EMPTY, cursor 0, player 0, counter 0, next state PLAY. No reject.
- select in PLAY:
  - Target cell EMPTY: write P1 or P2 according to player, toggle player, counter+1. Go to FULL if the new counter == N. Cursor unchanged.
  - Target cell occupied: assert reject; no other change.
- select in FULL: assert reject; no change.
- Cursor moves are allowed in both states.
  - move: (cursor+1) mod N.
  - move_back: (cursor+N−1) mod N.
  - move_down: row = (row+1) mod ROWS, column kept, where row = cursor / COLS and col = cursor % COLS.
- counter never exceeds N. full is combinational from state == FULL.

## Timing
- Reset values: cells all 0 (EMPTY), cursor 0, player 0, counter 0, full 0, reject 0, state PLAY, edge registers 0.
- Latency: an input first sampled 1 at clock edge k, after being 0 at edge k−1, updates cells, cursor, player, counter and state at edge k. The update is visible in the following cycle.
- reject is high for exactly the cycle after edge k.
- An input held high for any number of cycles acts once. Releasing it for one sampled cycle re-arms it.
- Reset asserted mid-operation clears everything immediately and asynchronously, including the edge registers. A button still held when reset releases therefore counts as a new edge on the first clock.
- Edge cases:
  - Commit of the N-th mark: full rises in the same update.
  - Select and clear in the same cycle: clear wins.
  - Move while FULL: cursor moves, full stays 1.

## Structure
- Package grid_pkg holds:
  - cell_t codes: EMPTY = 0, P1 = 1, P2 = 2, widened to CELL_W.
  - state_t enum {PLAY, FULL}.
  - A function for the row/column wrap arithmetic.
- Sub-module edge_rise (clk, rst, in, pulse), instantiated five times.
- Board storage is a register array of N cell_t entries, flattened onto cells.

## Test plan
- Reset release with all inputs low (4×4) → cursor 0, cells all 0, player 0, counter 0, full 0.
- move pulsed 3 times → cursor 3. move_back from cursor 0 → 15. move_down from cursor 14 → 2. move held high for 10 cycles → exactly one step.
- select at cursor 3 → cell 3 = 1, player 1, counter 1. Second select at cursor 3 → one-cycle reject, cell 3 still 1, counter still 1.
- Alternating select/move over all 16 cells → cells alternate 1,2,1,2…, counter 16, full 1. A further select → reject, board unchanged. A move still steps the cursor.
- select and clear rising in the same cycle → board all 0, counter 0, no reject. select and move together → mark written, cursor unchanged.
- rst asserted low mid-game (counter 7, cursor 9) without a clock edge → all outputs return to reset values immediately. select held high across reset release → one commit at cell 0 on the first clock.

Source files
------------

// File: rtl/grid_pkg.sv
// Shared types and helpers for the grid cursor board controller.
package grid_pkg;

    // Cell codes; the top zero-extends them to its configured cell width.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        P1    = 2'd1,
        P2    = 2'd2
    } cell_t;

    // Game phase: marks accepted in PLAY, only cursor moves in FULL.
    typedef enum logic {
        PLAY = 1'b0,
        FULL = 1'b1
    } state_t;

    // Modular step used for linear, backward and row-wise cursor wrap.
    function automatic int unsigned wrap_inc(input int unsigned value,
                                             input int unsigned step,
                                             input int unsigned modulus);
        return (value + step) % modulus;
    endfunction

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector: one-cycle pulse when a level input goes 0 -> 1.
module edge_rise (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulse
);

    logic prev;

    // Remember the previous sample; cleared by reset so a held level re-fires.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev <= 1'b0;
        end else begin
            prev <= in;
        end
    end

    assign pulse = in & ~prev;

endmodule

// File: rtl/grid_cursor_ctrl.sv
// Board controller: ROWS x COLS cell array, 2-D wrapping cursor,
// alternating player marks, move counter and board-full tracking.
module grid_cursor_ctrl
    import grid_pkg::*;
#(
    parameter  int ROWS   = 4,
    parameter  int COLS   = 4,
    parameter  int CELL_W = 4,
    localparam int N      = ROWS * COLS,
    localparam int IDX_W  = $clog2(N),
    localparam int CNT_W  = $clog2(N + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                move,
    input  logic                move_back,
    input  logic                move_down,
    input  logic                select,
    input  logic                clear,
    output logic [N*CELL_W-1:0] cells,
    output logic [IDX_W-1:0]    cursor,
    output logic                player,
    output logic [CNT_W-1:0]    counter,
    output logic                full,
    output logic                reject
);

    logic move_p, back_p, down_p, select_p, clear_p;

    edge_rise u_edge_move   (.clk(clk), .rst(rst), .in(move),      .pulse(move_p));
    edge_rise u_edge_back   (.clk(clk), .rst(rst), .in(move_back), .pulse(back_p));
    edge_rise u_edge_down   (.clk(clk), .rst(rst), .in(move_down), .pulse(down_p));
    edge_rise u_edge_select (.clk(clk), .rst(rst), .in(select),    .pulse(select_p));
    edge_rise u_edge_clear  (.clk(clk), .rst(rst), .in(clear),     .pulse(clear_p));

    state_t            state, state_next;
    logic [CELL_W-1:0] board      [N];
    logic [CELL_W-1:0] board_next [N];
    logic [IDX_W-1:0]  cursor_next;
    logic              player_next;
    logic [CNT_W-1:0]  counter_next;
    logic              reject_next;

    int unsigned cur_row, cur_col;

    assign cur_row = 32'(cursor) / COLS;
    assign cur_col = 32'(cursor) % COLS;

    // State and datapath registers; reset empties the board immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= PLAY;
            cursor  <= '0;
            player  <= 1'b0;
            counter <= '0;
            reject  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                board[i] <= '0;
            end
        end else begin
            state   <= state_next;
            cursor  <= cursor_next;
            player  <= player_next;
            counter <= counter_next;
            reject  <= reject_next;
            for (int i = 0; i < N; i++) begin
                board[i] <= board_next[i];
            end
        end
    end

    // Next-state logic: only the highest-priority event of the cycle acts.
    always_comb begin
        state_next   = state;
        cursor_next  = cursor;
        player_next  = player;
        counter_next = counter;
        reject_next  = 1'b0;
        board_next   = board;

        if (clear_p) begin
            for (int i = 0; i < N; i++) begin
                board_next[i] = '0;
            end
            cursor_next  = '0;
            player_next  = 1'b0;
            counter_next = '0;
            state_next   = PLAY;
        end else if (select_p) begin
            if (state == PLAY && board[cursor] == CELL_W'(EMPTY)) begin
                board_next[cursor] = player ? CELL_W'(P2) : CELL_W'(P1);
                player_next        = ~player;
                counter_next       = counter + CNT_W'(1);
                if (counter_next == CNT_W'(N)) begin
                    state_next = FULL;
                end
            end else begin
                reject_next = 1'b1;
            end
        end else if (move_p) begin
            cursor_next = IDX_W'(wrap_inc(32'(cursor), 1, N));
        end else if (back_p) begin
            cursor_next = IDX_W'(wrap_inc(32'(cursor), N - 1, N));
        end else if (down_p) begin
            cursor_next = IDX_W'(wrap_inc(cur_row, 1, ROWS) * COLS + cur_col);
        end
    end

    assign full = (state == FULL);

    // Flatten the board array onto the renderer bus.
    for (genvar g = 0; g < N; g++) begin : g_flat
        assign cells[g*CELL_W +: CELL_W] = board[g];
    end

endmodule

// File: tb/tb_grid_cursor_ctrl.sv
// Directed self-checking bench for grid_cursor_ctrl on the default 4x4 board.
module tb_grid_cursor_ctrl;

    localparam logic [4:0] NONE = 5'b00000;
    localparam logic [4:0] MOVE = 5'b00001;
    localparam logic [4:0] BACK = 5'b00010;
    localparam logic [4:0] DOWN = 5'b00100;
    localparam logic [4:0] SEL  = 5'b01000;
    localparam logic [4:0] CLR  = 5'b10000;

    logic        clk;
    logic        rst;
    logic        move, move_back, move_down, select, clear;
    logic [63:0] cells;
    logic [3:0]  cursor;
    logic        player;
    logic [4:0]  counter;
    logic        full;
    logic        reject;

    int vectors;
    int miscompares;

    grid_cursor_ctrl #(.ROWS(4), .COLS(4), .CELL_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .move      (move),
        .move_back (move_back),
        .move_down (move_down),
        .select    (select),
        .clear     (clear),
        .cells     (cells),
        .cursor    (cursor),
        .player    (player),
        .counter   (counter),
        .full      (full),
        .reject    (reject)
    );

    // Free-running 100 MHz-style clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive the button levels, then advance the given number of cycles (to a falling edge).
    task automatic applyStimulus(input logic [4:0] btn, input int cycles);
        move      = btn[0];
        move_back = btn[1];
        move_down = btn[2];
        select    = btn[3];
        clear     = btn[4];
        repeat (cycles) @(negedge clk);
    endtask

    // One press-and-release of the given buttons.
    task automatic pulse(input logic [4:0] btn);
        applyStimulus(btn, 1);
        applyStimulus(NONE, 1);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Directed sequence following the board's expected behaviour step by step.
    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        applyStimulus(NONE, 2);
        rst = 1'b1;
        applyStimulus(NONE, 1);

        checkOutput("reset_cursor",  64'(cursor),  64'd0);
        checkOutput("reset_cells",   cells,        64'd0);
        checkOutput("reset_player",  64'(player),  64'd0);
        checkOutput("reset_counter", 64'(counter), 64'd0);
        checkOutput("reset_full",    64'(full),    64'd0);
        checkOutput("reset_reject",  64'(reject),  64'd0);

        // Cursor arithmetic.
        repeat (3) pulse(MOVE);
        checkOutput("move_x3", 64'(cursor), 64'd3);
        repeat (3) pulse(BACK);
        checkOutput("back_to_0", 64'(cursor), 64'd0);
        pulse(BACK);
        checkOutput("back_wrap", 64'(cursor), 64'd15);
        pulse(BACK);
        checkOutput("back_14", 64'(cursor), 64'd14);
        pulse(DOWN);
        checkOutput("down_wrap", 64'(cursor), 64'd2);
        applyStimulus(MOVE, 10);
        applyStimulus(NONE, 1);
        checkOutput("move_held", 64'(cursor), 64'd3);

        // First commit and occupied-cell refusal.
        applyStimulus(SEL, 1);
        checkOutput("sel1_reject", 64'(reject), 64'd0);
        checkOutput("sel1_cells",  cells, 64'h0000_0000_0000_1000);
        applyStimulus(NONE, 1);
        checkOutput("sel1_player",  64'(player),  64'd1);
        checkOutput("sel1_counter", 64'(counter), 64'd1);
        applyStimulus(SEL, 1);
        checkOutput("sel2_reject", 64'(reject), 64'd1);
        applyStimulus(NONE, 1);
        checkOutput("sel2_reject_gone", 64'(reject),  64'd0);
        checkOutput("sel2_cells",       cells,        64'h0000_0000_0000_1000);
        checkOutput("sel2_counter",     64'(counter), 64'd1);

        // Fill the whole board with alternating marks.
        pulse(CLR);
        checkOutput("clr_cells",  cells,        64'd0);
        checkOutput("clr_player", 64'(player),  64'd0);
        for (int i = 0; i < 16; i++) begin
            pulse(SEL);
            if (i == 14) begin
                checkOutput("fill15_full", 64'(full), 64'd0);
            end
            pulse(MOVE);
        end
        checkOutput("fill_cells",   cells,        64'h2121_2121_2121_2121);
        checkOutput("fill_counter", 64'(counter), 64'd16);
        checkOutput("fill_full",    64'(full),    64'd1);
        checkOutput("fill_cursor",  64'(cursor),  64'd0);
        applyStimulus(SEL, 1);
        checkOutput("full_sel_reject", 64'(reject), 64'd1);
        applyStimulus(NONE, 1);
        checkOutput("full_sel_cells",   cells,        64'h2121_2121_2121_2121);
        checkOutput("full_sel_counter", 64'(counter), 64'd16);
        pulse(MOVE);
        checkOutput("full_move_cursor", 64'(cursor), 64'd1);
        checkOutput("full_move_full",   64'(full),   64'd1);

        // Simultaneous events.
        applyStimulus(SEL | CLR, 1);
        checkOutput("selclr_reject", 64'(reject), 64'd0);
        applyStimulus(NONE, 1);
        checkOutput("selclr_cells",   cells,        64'd0);
        checkOutput("selclr_counter", 64'(counter), 64'd0);
        checkOutput("selclr_full",    64'(full),    64'd0);
        pulse(SEL | MOVE);
        checkOutput("selmove_cells",  cells,        64'h0000_0000_0000_0001);
        checkOutput("selmove_cursor", 64'(cursor),  64'd0);

        // Asynchronous reset mid-game.
        pulse(CLR);
        for (int i = 0; i < 7; i++) begin
            pulse(SEL);
            pulse(MOVE);
        end
        repeat (2) pulse(MOVE);
        checkOutput("mid_counter", 64'(counter), 64'd7);
        checkOutput("mid_cursor",  64'(cursor),  64'd9);
        checkOutput("mid_cells",   cells,        64'h0000_0000_0121_2121);
        #2 rst = 1'b0;
        #1;
        checkOutput("async_cursor",  64'(cursor),  64'd0);
        checkOutput("async_counter", 64'(counter), 64'd0);
        checkOutput("async_cells",   cells,        64'd0);
        checkOutput("async_player",  64'(player),  64'd0);
        @(negedge clk);
        applyStimulus(SEL, 2);
        rst = 1'b1;
        applyStimulus(SEL, 1);
        checkOutput("held_sel_cells",   cells,        64'h0000_0000_0000_0001);
        checkOutput("held_sel_counter", 64'(counter), 64'd1);
        checkOutput("held_sel_player",  64'(player),  64'd1);
        applyStimulus(SEL, 3);
        checkOutput("held_sel_once", 64'(counter), 64'd1);
        applyStimulus(NONE, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
